// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: op codes, FSM
// states, widths and the flag bundle.
package mul_pkg;

  localparam int unsigned ITER  = 32;
  localparam int unsigned OP_W  = 32;
  localparam int unsigned ACC_W = 2 * OP_W;
  localparam int unsigned RA_W  = 4;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_SMULL = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_WR_LO = 3'd2,
    ST_WR_HI = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] x);
    return x[OP_W-1] ? OP_W'(~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add datapath: operand shift registers and 64-bit accumulator.
// product includes the step being taken this cycle so the final value is
// visible on the same edge that retires the last iteration.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int unsigned W = OP_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product
);

  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] addend;
  logic [2*W-1:0] acc_sum;

  assign addend  = mplier_q[0] ? mcand_q : '0;
  assign acc_sum = acc_q + addend;
  assign product = step ? acc_sum : acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (clear) begin
      mcand_q  <= {W'(0), a};
      mplier_q <= b;
      acc_q    <= '0;
    end else if (step) begin
      mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[W-1:1]};
      acc_q    <= acc_sum;
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential multiplier (MUL/UMULL/SMULL) that writes its result through a
// register-file write port and reports N/Z flags.
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned ITER = mul_pkg::ITER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [RA_W-1:0]   rd_lo,
  input  logic [RA_W-1:0]   rd_hi,
  output logic              busy,
  output logic              done,
  output logic              reg_we,
  output logic [RA_W-1:0]   reg_wa,
  output logic [OP_W-1:0]   reg_wd,
  output logic [3:0]        flags
);

  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  op_e                op_q, op_dec;
  logic               sign_q;
  logic [RA_W-1:0]    rd_lo_q, rd_hi_q;
  flags_t             flags_q, flags_d;

  logic               clear, step, is_long;
  logic [OP_W-1:0]    a_in, b_in;
  logic [ACC_W-1:0]   raw, prod;

  logic               busy_d, done_d, reg_we_d;
  logic [RA_W-1:0]    reg_wa_d;
  logic [OP_W-1:0]    reg_wd_d;

  // Reserved encoding behaves as plain MUL.
  always_comb begin
    op_dec = OP_MUL;
    if (op == OP_UMULL)      op_dec = OP_UMULL;
    else if (op == OP_SMULL) op_dec = OP_SMULL;
  end

  assign a_in    = (op_dec == OP_SMULL) ? mag(a) : a;
  assign b_in    = (op_dec == OP_SMULL) ? mag(b) : b;
  assign is_long = (op_q == OP_UMULL) || (op_q == OP_SMULL);
  assign prod    = (op_q == OP_SMULL && sign_q) ? ACC_W'(~raw + 1'b1) : raw;

  mul_shift_add #(.W(OP_W)) u_dp (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .step    (step),
    .a       (a_in),
    .b       (b_in),
    .product (raw)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, datapath control and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    step     = 1'b0;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
          clear   = 1'b1;
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_WR_LO;
      end
      ST_WR_LO: state_d = is_long ? ST_WR_HI : ST_DONE;
      ST_WR_HI: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    reg_we_d = 1'b0;
    reg_wa_d = '0;
    reg_wd_d = '0;
    if (state_d == ST_WR_LO) begin
      reg_we_d  = 1'b1;
      reg_wa_d  = rd_lo_q;
      reg_wd_d  = prod[OP_W-1:0];
      flags_d.c = 1'b0;
      flags_d.v = 1'b0;
      if (is_long) begin
        flags_d.n = prod[ACC_W-1];
        flags_d.z = (prod == '0);
      end else begin
        flags_d.n = prod[OP_W-1];
        flags_d.z = (prod[OP_W-1:0] == '0);
      end
    end else if (state_d == ST_WR_HI) begin
      reg_we_d = 1'b1;
      reg_wa_d = rd_hi_q;
      reg_wd_d = prod[ACC_W-1:OP_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      sign_q  <= 1'b0;
      rd_lo_q <= '0;
      rd_hi_q <= '0;
    end else if (clear) begin
      cnt_q   <= '0;
      op_q    <= op_dec;
      sign_q  <= (op_dec == OP_SMULL) && (a[OP_W-1] ^ b[OP_W-1]);
      rd_lo_q <= rd_lo;
      rd_hi_q <= rd_hi;
    end else if (step) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      reg_we  <= 1'b0;
      reg_wa  <= '0;
      reg_wd  <= '0;
      flags_q <= '0;
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      reg_we  <= reg_we_d;
      reg_wa  <= reg_wa_d;
      reg_wd  <= reg_wd_d;
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: expected writes are queued when an op is
// launched and retired against the register write port as it fires.
module tb_mul_seq;

  typedef struct packed {
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [7:0]  cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [3:0]  rd_lo, rd_hi;
  logic        busy, done, reg_we;
  logic [3:0]  reg_wa;
  logic [31:0] reg_wd;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_errors = 0;
  wr_t exp_q[$];

  mul_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_lo  (rd_lo),
    .rd_hi  (rd_hi),
    .busy   (busy),
    .done   (done),
    .reg_we (reg_we),
    .reg_wa (reg_wa),
    .reg_wd (reg_wd),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Retire one observed write against the head of the scoreboard.
  task automatic check_write(input int c);
    wr_t e;
    if (exp_q.size() == 0) begin
      check("we_unexpected", {60'd0, reg_wa}, 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("reg_wa", 64'(reg_wa), 64'(e.wa));
      check("reg_wd", 64'(reg_wd), 64'(e.wd));
      check("wr_cycle", 64'(c), 64'(e.cyc));
    end
  endtask

  // Launch one op (called at a negedge) and follow it to completion.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] lo, input logic [3:0] hi, input int restart_at);
    logic [63:0]        p;
    logic signed [63:0] sx, sy;
    logic               lng, seen_done, busy_ok, port_ok;
    logic [3:0]         fl;
    int                 c;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    lng = (o == 2'b01) || (o == 2'b10);
    if (o == 2'b10) p = sx * sy;
    else            p = {32'd0, x} * {32'd0, y};
    if (lng) fl = {p[63], p == 64'd0, 2'b00};
    else     fl = {p[31], p[31:0] == 32'd0, 2'b00};
    exp_q.push_back('{wa: lo, wd: p[31:0], cyc: 8'd33});
    if (lng) exp_q.push_back('{wa: hi, wd: p[63:32], cyc: 8'd34});

    start = 1'b1; op = o; a = x; b = y; rd_lo = lo; rd_hi = hi;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; rd_lo = 4'($urandom); rd_hi = 4'($urandom);
    seen_done = 1'b0; busy_ok = 1'b1; port_ok = 1'b1; c = 0;
    while (!seen_done && c < 60) begin
      @(negedge clk);
      c++;
      if (c == restart_at) begin
        start = 1'b1; op = 2'b01; a = ~x; b = y + 32'd1;
      end else if (c == restart_at + 1) begin
        start = 1'b0;
      end
      if (!busy) busy_ok = 1'b0;
      if (reg_we) check_write(c);
      else if (reg_wa != 4'd0 || reg_wd != 32'd0) port_ok = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", 64'(c), lng ? 64'd35 : 64'd34);
        check("flags", 64'(flags), 64'(fl));
      end
    end
    if (!seen_done) check("done_timeout", 64'd0, 64'd1);
    check("busy_held", 64'(busy_ok), 64'd1);
    check("wport_idle_zero", 64'(port_ok), 64'd1);
    check("writes_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    check("busy_after", 64'(busy), 64'd0);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic we_seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; rd_lo = '0; rd_hi = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(reg_we), 64'd0);
    check("rst_wa_wd", {28'd0, reg_wa, reg_wd}, 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    reset = 1'b0;

    run_op(2'b00, 32'd7, 32'd6, 4'd3, 4'd9, 0);
    check("mul7x6_flags", 64'(flags), 64'd0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 4'd2, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 4'd4, 4'd5, 0);
    run_op(2'b10, 32'h8000_0000, 32'h8000_0000, 4'd6, 4'd7, 0);
    run_op(2'b10, 32'h8000_0000, 32'd3, 4'd6, 4'd7, 0);
    run_op(2'b11, 32'h0000_1234, 32'h0000_0100, 4'd8, 4'd0, 0);
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 4'd2, 4'd0, 0);
    check("z_flag_set", 64'(flags), 64'h4);

    // Abort mid-CALC: outputs clear at once and no write ever appears.
    start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h55; rd_lo = 4'd1; rd_hi = 4'd2;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_flags", 64'(flags), 64'd0);
    check("abort_we", 64'(reg_we), 64'd0);
    we_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (reg_we || busy) we_seen = 1'b1;
    end
    check("abort_quiet", 64'(we_seen), 64'd0);
    reset = 1'b0;
    run_op(2'b00, 32'd3, 32'd5, 4'd10, 4'd0, 0);

    run_op(2'b00, 32'd100, 32'd200, 4'd11, 4'd0, 5);
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 4'd5, 4'd5, 0);
    for (int i = 0; i < 6; i++)
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom), 4'($urandom), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning the number of shift-add iterations, equal to the operand width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: 00 MUL, 01 UMULL, 10 SMULL, 11 reserved and treated as MUL.
REQ-006 SHALL have ports a and b, input, 32 bits each: multiplicand and multiplier.
REQ-007 SHALL have ports rd_lo and rd_hi, input, 4 bits each: destination register numbers (RdLo/Rd and RdHi).
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have ports reg_we (1 bit), reg_wa (4 bits) and reg_wd (32 bits), outputs: register-file write port.
REQ-011 SHALL have port flags, output, 4 bits: {N,Z,C,V} from the last completed multiply.

Function
REQ-012 SHALL implement the FSM IDLE -> CALC -> WR_LO -> [WR_HI when the op is UMULL or SMULL] -> DONE -> IDLE.
REQ-013 SHALL, on the edge where IDLE sees start=1, latch a, b, op, rd_lo and rd_hi, clear the 64-bit accumulator and the iteration counter, and enter CALC.
REQ-014 SHALL ignore start in every state other than IDLE; latched operands stay unchanged until the next accepted start.
REQ-015 SHALL, for SMULL, latch the magnitudes |a| and |b| plus sign = a[31]^b[31]; a value of 0x80000000 SHALL be treated as magnitude 0x80000000 unsigned.
REQ-016 SHALL, in CALC, perform one radix-2 shift-add step per cycle for exactly ITER cycles (counter 0..ITER-1), then move to WR_LO.
REQ-017 SHALL form the final product as the 64-bit two's-complement negation of the accumulator when op is SMULL and sign=1; otherwise the product is the accumulator unchanged.
REQ-018 SHALL, in WR_LO, drive reg_we=1, reg_wa=rd_lo and reg_wd=product[31:0].
REQ-019 SHALL, in WR_HI, drive reg_we=1, reg_wa=rd_hi and reg_wd=product[63:32].
REQ-020 SHALL let the later WR_HI write take effect when rd_lo equals rd_hi; no special handling is required.
REQ-021 SHALL update flags on the WR_LO edge as follows:
- MUL: N = product[31], Z = (product[31:0]==0).
- UMULL/SMULL: N = product[63], Z = (product[63:0]==0).
- C = 0 and V = 0 in all cases.
REQ-022 SHALL assert done for exactly one cycle, in DONE.
REQ-023 SHALL meet the following latency, with start accepted at edge 0:
- CALC occupies cycles 1..32.
- WR_LO occurs in cycle 33.
- MUL: done in cycle 34.
- Long ops: WR_HI in cycle 34, done in cycle 35.
REQ-024 SHALL drive reg_we=0, reg_wa=0 and reg_wd=0 in every state other than WR_LO and WR_HI.

Reset
REQ-025 SHALL, while reset=1, force:
- state=IDLE and counter=0;
- accumulator and latched operands to 0;
- busy=0, done=0, reg_we=0, reg_wa=0, reg_wd=0;
- flags=4'b0000.
REQ-026 SHALL, when reset is asserted in any state (including mid-CALC or WR_LO), abort the operation with no further register writes and leave flags at 0.
REQ-027 SHALL honour start on the first rising clk edge after reset deasserts.

Structure
REQ-028 SHALL place the op encodings (MUL, UMULL, SMULL), the FSM state encoding and ITER in the shared package mul_pkg.
REQ-029 SHALL split the design into one sub-module, mul_shift_add, which holds the accumulator, operand shift registers and add step (ports: clk, reset, clear, step, a, b, product), plus the mul_seq FSM.

Verification
REQ-030 MUL 7 x 6 with rd_lo=3 -> WR_LO writes reg_wa=3, reg_wd=0x0000002A in cycle 33; done in cycle 34; flags=0000.
REQ-031 UMULL 0xFFFFFFFF x 0xFFFFFFFF with rd_lo=1, rd_hi=2 -> writes 1<=0x00000001 and 2<=0xFFFFFFFE; done in cycle 35; flags=1000.
REQ-032 SMULL signed-product checks:
- 0xFFFFFFFF x 2 -> lo=0xFFFFFFFE, hi=0xFFFFFFFF, flags=1000.
- 0x80000000 x 0x80000000 -> lo=0x00000000, hi=0x40000000, flags=0000.
REQ-033 MUL 0x00010000 x 0x00010000 -> reg_wd=0x00000000, flags=0100.
REQ-034 A second start in CALC cycle 5 with different operands -> ignored; the first result is written unchanged; busy stays 1 until DONE completes.
REQ-035 Reset pulsed in CALC cycle 10 -> reg_we never asserts, busy=0 and flags=0000 immediately; a new MUL 3 x 5 after reset yields 0x0000000F.
